// File: rtl/four_bits_counter.sv
// Free-running modulo-(MAX_COUNT+1) up-counter with a registered wrap indication.
// Latency: counter shows 1 on the first edge after reset drops; overflow is registered alongside the wrap to 0.
// Backpressure: none; the counter advances on every non-reset edge and has no enable or load input.
//
// Optional build macro FOUR_BITS_COUNTER_STICKY_OVF_EN: when defined, overflow sets on
// the first wrap and holds until a reset edge; when undefined, overflow is a one-cycle
// pulse marking the cycle in which counter is 0 after a wrap.
//
// Several instances may run from unrelated clocks and share one reset net; each
// instance samples reset only on its own clock edge.

module four_bits_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] counter,
  output logic             overflow
);

  // Reject configurations that would make the terminal count unreachable or the
  // counter degenerate.
  if (WIDTH < 1) begin : g_bad_width
    $error("four_bits_counter: WIDTH must be at least 1");
  end
  if ((MAX_COUNT < 0) || (MAX_COUNT > (2 ** WIDTH) - 1)) begin : g_bad_max
    $error("four_bits_counter: MAX_COUNT must lie in 0 .. 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] TERMINAL = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1} ;

  // Declaration initialisers keep simulation free of X before the first reset
  // edge; the real power-up value is a don't-care.
  logic [WIDTH-1:0] count_q = '0;
  logic             ovf_q   = 1'b0;
  logic             at_terminal;

  // The wrap decision is taken from the registered count only, so no input
  // reaches an output without passing through a flop.
  assign at_terminal = (count_q == TERMINAL);

  // Count register: reset wins over a wrap on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (at_terminal) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + ONE;
    end
  end

`ifdef FOUR_BITS_COUNTER_STICKY_OVF_EN
  // Sticky wrap flag: sets on the first wrap, clears only on a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (at_terminal) begin
      ovf_q <= 1'b1;
    end
  end
`else
  // Wrap pulse: high exactly for the cycle in which the count is 0 after a wrap,
  // never for the post-reset 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= at_terminal;
    end
  end
`endif

  assign counter  = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_four_bits_counter.sv
// Directed bench for four_bits_counter: reset, counting, wrap, reset mid-count,
// reset on the wrap edge, a non-default MAX_COUNT, and three instances on
// unrelated clocks sharing one reset net.

module tb_four_bits_counter;

  logic       clk    = 1'b0;
  logic       clk24  = 1'b0;
  logic       clk50  = 1'b0;
  logic       clk100 = 1'b0;
  logic       rst    = 1'b1;
  logic       rst_m  = 1'b1;

  logic [3:0] cnt;
  logic       ovf;
  logic [3:0] cnt9;
  logic       ovf9;
  logic [3:0] cnt24;
  logic       ovf24;
  logic [3:0] cnt50;
  logic       ovf50;
  logic [3:0] cnt100;
  logic       ovf100;

  int errors = 0;
  int checks = 0;

  four_bits_counter dut (
    .clk      (clk),
    .reset    (rst),
    .counter  (cnt),
    .overflow (ovf)
  );

  four_bits_counter #(.WIDTH(4), .MAX_COUNT(9)) dut9 (
    .clk      (clk),
    .reset    (rst),
    .counter  (cnt9),
    .overflow (ovf9)
  );

  four_bits_counter u24 (
    .clk      (clk24),
    .reset    (rst_m),
    .counter  (cnt24),
    .overflow (ovf24)
  );

  four_bits_counter u50 (
    .clk      (clk50),
    .reset    (rst_m),
    .counter  (cnt50),
    .overflow (ovf50)
  );

  four_bits_counter u100 (
    .clk      (clk100),
    .reset    (rst_m),
    .counter  (cnt100),
    .overflow (ovf100)
  );

  // Main clock: posedges at 5, 15, 25, ...
  initial forever #5 clk = ~clk;
  // Posedges at 12 + 24k.
  initial forever #12 clk24 = ~clk24;
  // Posedges at 25 + 50k.
  initial forever #25 clk50 = ~clk50;
  // Posedges at 80 + 100k.
  initial begin
    #80;
    forever begin
      clk100 = ~clk100;
      #50;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one main-clock edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- Shared reset across three clocks: high 0..53, low 53..253, high 253..303
    #40;
    chk("mc_init_c24",  cnt24,  0);
    chk("mc_init_c50",  cnt50,  0);
    chk("mc_init_c100", cnt100, 0);
    #13;  rst_m = 1'b0;                       // t=53
    #197;                                     // t=250
    chk("mc_run_c24",  cnt24,  8);            // edges 60..228
    chk("mc_run_c50",  cnt50,  4);            // edges 75..225
    chk("mc_run_c100", cnt100, 2);            // edges 80,180
    chk("mc_run_o24",  ovf24,  0);
    #3;   rst_m = 1'b1;                       // t=253
    #37;                                      // t=290
    chk("mc_rst_c24",  cnt24,  0);            // reset edge 276
    chk("mc_rst_c50",  cnt50,  0);            // reset edge 275
    chk("mc_rst_c100", cnt100, 0);            // reset edge 280
    chk("mc_rst_o100", ovf100, 0);
    #13;  rst_m = 1'b0;                       // t=303
    #27;                                      // t=330
    chk("mc_rel_c24",  cnt24,  1);            // edge 324
    chk("mc_rel_c50",  cnt50,  1);            // edge 325
    chk("mc_rel_c100", cnt100, 0);            // next edge 380

    // ---- Reset held for 3 edges, then release
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_cnt", cnt, 0);
      chk("rst_hold_ovf", ovf, 0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("release_cnt", cnt, i);
      chk("release_ovf", ovf, 0);
    end

    // ---- 16 edges from reset release: 1..15 then wrap to 0 with overflow
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("wrap_cnt", cnt, i % 16);
      chk("wrap_ovf", ovf, (i == 16) ? 1 : 0);
    end
    tick();
    chk("after_wrap_cnt", cnt, 1);
`ifdef FOUR_BITS_COUNTER_STICKY_OVF_EN
    chk("after_wrap_ovf", ovf, 1);
`else
    chk("after_wrap_ovf", ovf, 0);
`endif

    // ---- Reset mid-count at 9
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_pre_cnt", cnt, 9);
    rst = 1'b1;
    tick();
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();
    chk("mid_resume_cnt", cnt, 1);
    chk("mid_resume_ovf", ovf, 0);

    // ---- Reset on the edge that would wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("term_pre_cnt", cnt, 15);
    chk("term_pre_ovf", ovf, 0);
    rst = 1'b1;
    tick();
    chk("term_rst_cnt", cnt, 0);
    chk("term_rst_ovf", ovf, 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("term_after_cnt", cnt, i);
      chk("term_after_ovf", ovf, 0);
    end

    // ---- 40 edges after reset; also covers the MAX_COUNT=9 instance
    rst = 1'b1;
    tick();
    chk("long_rst_cnt9", cnt9, 0);
    chk("long_rst_ovf9", ovf9, 0);
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("long_cnt",  cnt,  i % 16);
      chk("long_cnt9", cnt9, i % 10);
`ifdef FOUR_BITS_COUNTER_STICKY_OVF_EN
      chk("long_ovf",  ovf,  (i >= 16) ? 1 : 0);
      chk("long_ovf9", ovf9, (i >= 10) ? 1 : 0);
`else
      chk("long_ovf",  ovf,  (i % 16 == 0) ? 1 : 0);
      chk("long_ovf9", ovf9, (i % 10 == 0) ? 1 : 0);
`endif
    end
    rst = 1'b1;
    tick();
    chk("long_clr_cnt", cnt, 0);
    chk("long_clr_ovf", ovf, 0);
    chk("long_clr_ovf9", ovf9, 0);
    rst = 1'b0;
    tick();
    chk("long_rel_cnt", cnt, 1);
    chk("long_rel_ovf", ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
